// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder with done flag, cycle counter and write-trace FIFO
module data_mem_responder #(
   parameter int unsigned MEM_SIZE_WORDS = 1024,
   parameter logic [31:0] DONE_ADDR      = 32'h400,
   parameter logic [31:0] TRACE_LO       = 32'h300,
   parameter logic [31:0] TRACE_HI       = 32'h324,
   parameter int unsigned TRACE_DEPTH    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d_mem_addr,
   input  logic [31:0] d_mem_wdata,
   input  logic [3:0]  d_mem_wen,
   output logic [31:0] d_mem_rdata,
   output logic        done,
   output logic        timeout,
   output logic [31:0] cycle_count,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic [3:0]  trace_wen,
   output logic        trace_overflow
);
   localparam int unsigned IDXW      = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
   localparam int unsigned PW        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
   localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE_WORDS) * 33'd4;
   localparam logic [PW:0] DEPTH_C   = (PW + 1)'(TRACE_DEPTH);

   logic [31:0] mem [MEM_SIZE_WORDS];

   logic [31:0] fifo_addr [TRACE_DEPTH];
   logic [31:0] fifo_data [TRACE_DEPTH];
   logic [3:0]  fifo_wen  [TRACE_DEPTH];

   logic            done_q, done_d;
   logic            timeout_q, timeout_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]     count_q, count_d;

   logic            in_range, wr_acc, done_set, trace_hit, cnt_inc;
   logic            fifo_full, fifo_empty, pop, push_ok;
   logic [IDXW-1:0] idx;

   assign in_range  = {1'b0, d_mem_addr} < MEM_BYTES;
   assign idx       = d_mem_addr[IDXW+1:2];
   assign wr_acc    = in_range && (d_mem_wen != 4'b0000);
   assign done_set  = wr_acc && (d_mem_wen == 4'b1111) &&
                      (d_mem_addr[31:2] == DONE_ADDR[31:2]) && (d_mem_wdata == 32'd1);
   assign trace_hit = wr_acc && (d_mem_addr >= TRACE_LO) && (d_mem_addr <= TRACE_HI);

   // RAM has no reset; writes are still blocked while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) begin
         for (int k = 0; k < 4; k++) begin
            if (d_mem_wen[k]) mem[idx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
         end
      end
   end

   assign d_mem_rdata = in_range ? mem[idx] : 32'h0;

   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_empty = (count_q == '0);
   assign pop        = !fifo_empty && trace_ready;
   assign push_ok    = trace_hit && (!fifo_full || pop);

   always_comb begin
      cnt_inc   = !done_q && !done_set && (cnt_q != 32'hFFFF_FFFF);
      cnt_d     = cnt_inc ? cnt_q + 32'd1 : cnt_q;
      done_d    = done_q | done_set;
      timeout_d = timeout_q | (cnt_inc && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES)));
      ovf_d     = ovf_q | (trace_hit && fifo_full && !pop);
      wptr_d    = push_ok ? wptr_q + PW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
      count_d   = count_q;
      if (push_ok && !pop) count_d = count_q + (PW + 1)'(1);
      else if (pop && !push_ok) count_d = count_q - (PW + 1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         done_q    <= done_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         fifo_addr[wptr_q] <= d_mem_addr;
         fifo_data[wptr_q] <= d_mem_wdata;
         fifo_wen[wptr_q]  <= d_mem_wen;
      end
   end

   // Head fields read as zero when empty so the reset values are clean.
   assign trace_valid    = !fifo_empty;
   assign trace_addr     = trace_valid ? fifo_addr[rptr_q] : 32'h0;
   assign trace_data     = trace_valid ? fifo_data[rptr_q] : 32'h0;
   assign trace_wen      = trace_valid ? fifo_wen[rptr_q]  : 4'h0;
   assign trace_overflow = ovf_q;
   assign done           = done_q;
   assign timeout        = timeout_q;
   assign cycle_count    = cnt_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synthesizable responder for the CPU data-memory port (`d_mem_*`), replacing the behavioural data memory used by program-level benches. It serves same-cycle reads and byte-lane writes from a word RAM and detects the software completion flag. It also counts execution cycles and captures a write trace of the result window into a small FIFO for a drain interface. It sits beside `cpu_top` in simulation tops and FPGA wrappers.

## Interface
- `MEM_SIZE_WORDS`, 1024: RAM depth in 32-bit words; byte range 0 .. 4*MEM_SIZE_WORDS-1.
- `DONE_ADDR`, 32'h400: completion-flag word address.
- `TRACE_LO`, 32'h300: lowest traced byte address (inclusive).
- `TRACE_HI`, 32'h324: highest traced byte address (inclusive).
- `TRACE_DEPTH`, 8: trace FIFO entries; power of two.
- `TIMEOUT_CYCLES`, 5000: cycle count at which `timeout` asserts.
- `clk  in  1  clock; all state updates on rising edge`
- `rst_n  in  1  reset; asynchronous, active-low`
- `d_mem_addr  in  32  byte address from CPU`
- `d_mem_wdata  in  32  write data`
- `d_mem_wen  in  4  byte-lane write enables; bit k covers wdata[8k+7:8k]`
- `d_mem_rdata  out  32  read data`
- `done  out  1  sticky completion flag`
- `timeout  out  1  sticky timeout flag`
- `cycle_count  out  32  cycles since reset release`
- `trace_valid  out  1  FIFO head valid`
- `trace_ready  in  1  drain accepts head`
- `trace_addr  out  32  head entry address`
- `trace_data  out  32  head entry write data`
- `trace_wen  out  4  head entry byte enables`
- `trace_overflow  out  1  sticky: a trace entry was dropped`

## Operation
- Address decode: word index = `d_mem_addr[31:2]`; `addr[1:0]` ignored. In range iff `d_mem_addr < 4*MEM_SIZE_WORDS`.
- Read: combinational. `d_mem_rdata = mem[index]` in range, else 32'h0. Valid regardless of `d_mem_wen`. Same-cycle read of a word being written returns the old value.
- Write: when `rst_n` high, in range, and `d_mem_wen != 0`, each enabled byte lane is updated at the rising edge. Out-of-range writes are ignored. They are not traced and do not set `done`.
- RAM contents are not cleared by reset.
- Done: set at the edge of a write with `d_mem_wen == 4'b1111`, word address `DONE_ADDR`, and `d_mem_wdata == 1`. The RAM word is written as normal. Other values or partial writes to `DONE_ADDR` update RAM only. `done` clears only on reset.
- Cycle counter:
  - Increments at each edge while `done == 0` and no done-setting write occurs in that cycle.
  - Saturates at 32'hFFFF_FFFF.
  - Frozen once `done` is set.
- Timeout: sets at the edge where `cycle_count` becomes `TIMEOUT_CYCLES`. It is sticky and never sets once `done` is set. The counter keeps running after timeout until `done` is set.
- Trace push: any accepted in-range write with `TRACE_LO <= d_mem_addr <= TRACE_HI` pushes {addr, wdata, wen}.
- Trace pop: happens when `trace_valid && trace_ready`. FIFO order is strict.
- Full: a push with no simultaneous pop is dropped and sets `trace_overflow`, which is sticky. A push and pop in the same cycle while full are both performed, with no overflow.
- Empty: a push and `trace_ready` in the same cycle perform the push only, because there is no head to pop.
- Reset low, at any time, asynchronously clears:
  - `done`, `timeout`, `cycle_count`
  - FIFO pointers and count, so `trace_valid` is 0
  - `trace_overflow`
  
  Writes are ignored while `rst_n` is low.

## Timing
- Read latency 0 cycles; write visible to reads in the cycle after the write edge.
- `done` is high in the cycle after the flag write edge. `cycle_count` holds the value it had during the flag-write cycle.
- Trace entry: `trace_valid` is high in the cycle after the pushing write edge. No fall-through.
- `trace_*` outputs are registered FIFO head contents. They are stable while `trace_valid && !trace_ready`.
- Reset values: `d_mem_rdata` follows RAM combinationally; all other outputs are 0.
- First increment occurs at the first rising edge with `rst_n` high, so `cycle_count == 1` after that edge.

## Test plan
- Word write then read: write 32'h0000_0005 to 0x300 with wen 4'b1111. Next cycle, reading 0x300 returns 32'h5. Trace head is {0x300, 0x5, 4'b1111} with `trace_valid` = 1.
- Byte lanes: write 32'h1122_3344 to 0x200 with wen 1111, then 32'h0000_AA00 with wen 4'b0010. Read 0x200 returns 32'h1122_AA44. Nothing is traced. A write to 0x1000 is ignored and a read of 0x1000 returns 0.
- Done: write 2 to 0x400. `done` stays 0 and a read returns 2. Then write 1. `done` is 1 the next cycle, `cycle_count` is frozen at its flag-cycle value, and it is unchanged 100 cycles later.
- Overflow: with `trace_ready` = 0, write 0x300, 0x304 .. 0x320 (9 words). The FIFO holds 8 entries and `trace_overflow` = 1. Draining with `trace_ready` = 1 yields addresses 0x300 .. 0x31C in order, then `trace_valid` = 0. Repeat with a push and pop in the same cycle while full: no overflow.
- Timeout: set `TIMEOUT_CYCLES` = 20 and issue no done write. `timeout` rises in the cycle `cycle_count` = 20 and `cycle_count` keeps counting. A later done write freezes the count while `timeout` stays 1.
- Reset mid-run: with 3 trace entries, `done` = 1 and `timeout` = 1, pulse `rst_n` low between edges. All flags, `cycle_count` and `trace_valid` go to 0 immediately. RAM word 0x300 still reads back its written value after release.
